// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin stream arbiter.
// rr_pick works on a fixed maximum width so that any N_REQ up to MAX_REQ can share it.
package wrr_arb_pkg;

    localparam int MAX_REQ = 64;
    localparam int MAX_IDW = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } pick_t;

    function automatic int idw_of(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    // Rotate so ptr+1 sits at bit 0, take the lowest set bit, then map back to a requester index.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [MAX_IDW-1:0] ptr,
                                      input int                 n);
        logic [2*MAX_REQ-1:0] dbl;
        logic [MAX_REQ-1:0]   rot;
        pick_t                res;
        int                   pos;
        res = '0;
        dbl = ({{MAX_REQ{1'b0}}, valid} << n) | {{MAX_REQ{1'b0}}, valid};
        rot = MAX_REQ'(dbl >> (int'(ptr) + 32'sd1));
        for (int j = 32'sd0; j < MAX_REQ; j++) begin
            if (!res.found && (j < n) && rot[j]) begin
                pos       = int'(ptr) + 32'sd1 + j;
                pos       = (pos >= n) ? (pos - n) : pos;
                res.found = 1'b1;
                res.idx   = MAX_IDW'(pos);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wrr_stream_arbiter_if.sv
// Requester-side and downstream-side handshake bundle of the arbiter.
// master = environment (requester FIFOs + downstream link), slave = arbiter.
interface wrr_stream_arbiter_if
    import wrr_arb_pkg::*;
#(
    parameter int N_REQ   = 8,
    parameter int DATAW   = 64,
    parameter int WEIGHTW = 4,
    parameter int IDW     = idw_of(N_REQ)
);
    logic [N_REQ-1:0]              i_valid;
    logic [N_REQ-1:0]              o_ready;
    logic [N_REQ-1:0][DATAW-1:0]   i_data;
    logic [N_REQ-1:0]              i_last;
    logic [N_REQ-1:0][WEIGHTW-1:0] i_weight;
    logic                          o_valid;
    logic                          i_ready;
    logic [DATAW-1:0]              o_data;
    logic                          o_last;
    logic [IDW-1:0]                o_grant_id;

    modport master (
        output i_valid, i_data, i_last, i_weight, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_grant_id
    );

    modport slave (
        input  i_valid, i_data, i_last, i_weight, i_ready,
        output o_ready, o_valid, o_data, o_last, o_grant_id
    );
endinterface

// File: rtl/rr_pointer_pick.sv
// Round-robin pick: first valid requester after ptr, with ptr itself scanned last.
module rr_pointer_pick
    import wrr_arb_pkg::*;
#(
    parameter int N_REQ = 8,
    parameter int IDW   = idw_of(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic             found_o,
    output logic [IDW-1:0]   idx_o
);
    pick_t pick_s;

    // Evaluate the shared pick function on zero-extended operands.
    always_comb begin
        pick_s = rr_pick(MAX_REQ'(valid_i), MAX_IDW'(ptr_i), N_REQ);
    end

    assign found_o = pick_s.found & (pick_s.idx < MAX_IDW'(N_REQ));
    assign idx_o   = pick_s.idx[IDW-1:0];
endmodule

// File: rtl/wrr_stream_arbiter.sv
// Weighted round-robin merge of N_REQ packet streams into one registered output stream.
// A grant covers up to `weight` packets and is never broken inside a packet when LOCK_EN=1.
module wrr_stream_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N_REQ   = 8,
    parameter int DATAW   = 64,
    parameter int WEIGHTW = 4,
    parameter int LOCK_EN = 1
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    wrr_stream_arbiter_if.slave bus
);
    localparam int IDW = idw_of(N_REQ);

    state_e             state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [WEIGHTW-1:0] credit_q, credit_d;
    logic               mid_pkt_q, mid_pkt_d;

    logic               valid_q;
    logic [DATAW-1:0]   data_q;
    logic               last_q;
    logic [IDW-1:0]     gid_q;

    logic               pick_found_s;
    logic [IDW-1:0]     pick_idx_s;
    logic [WEIGHTW-1:0] pick_weight_s;
    logic               own_valid_s;
    logic               own_last_s;
    logic               accept_s;
    logic               xfer_s;
    logic               pkt_end_s;
    logic [N_REQ-1:0]   ready_s;

    rr_pointer_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .valid_i (bus.i_valid),
        .ptr_i   (ptr_q),
        .found_o (pick_found_s),
        .idx_o   (pick_idx_s)
    );

    assign pick_weight_s = bus.i_weight[pick_idx_s];
    assign own_valid_s   = bus.i_valid[owner_q];
    assign own_last_s    = bus.i_last[owner_q];
    assign accept_s      = (state_q == BUSY) & (~valid_q | bus.i_ready);
    assign xfer_s        = accept_s & own_valid_s;
    assign pkt_end_s     = own_last_s | (LOCK_EN == 0);

    // Arbitration state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= IDW'(N_REQ - 1);
            credit_q  <= '0;
            mid_pkt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            credit_q  <= credit_d;
            mid_pkt_q <= mid_pkt_d;
        end
    end

    // Next-state: grant in IDLE, spend credit per packet end, release early if the owner goes quiet between packets.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        credit_d  = credit_q;
        mid_pkt_d = mid_pkt_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    owner_d  = pick_idx_s;
                    credit_d = (pick_weight_s == '0) ? WEIGHTW'(1) : pick_weight_s;
                    state_d  = BUSY;
                end else begin
                    state_d  = IDLE;
                end
            end
            BUSY: begin
                if (xfer_s) begin
                    if (pkt_end_s) begin
                        mid_pkt_d = 1'b0;
                        if (credit_q == WEIGHTW'(1)) begin
                            ptr_d   = owner_q;
                            state_d = IDLE;
                        end else begin
                            credit_d = credit_q - WEIGHTW'(1);
                        end
                    end else begin
                        mid_pkt_d = 1'b1;
                    end
                end else if (!own_valid_s && !mid_pkt_q) begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-requester accept: only the owner, and only when the output stage can take a beat.
    always_comb begin
        ready_s = '0;
        if (accept_s) begin
            ready_s[owner_q] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // One-entry output stage; a new beat may overwrite one leaving in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            gid_q   <= '0;
        end else if (xfer_s) begin
            valid_q <= 1'b1;
            data_q  <= bus.i_data[owner_q];
            last_q  <= own_last_s;
            gid_q   <= owner_q;
        end else if (bus.i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.o_ready    = ready_s;
    assign bus.o_valid    = valid_q;
    assign bus.o_data     = data_q;
    assign bus.o_last     = last_q;
    assign bus.o_grant_id = gid_q;
endmodule
